// File: rtl/ft2232h_pkg.sv
// ft2232h_pkg: shared constants and flag-FSM encoding for the FT2232H responder.
// Rev 1.0
`default_nettype none

package ft2232h_pkg;

  localparam int BYTE_W            = 8;
  localparam int PRECHARGE_DEFAULT = 2;

  typedef enum logic [1:0] {
    FLAG_READY     = 2'd0,
    FLAG_BUSY      = 2'd1,
    FLAG_PRECHARGE = 2'd2
  } flag_state_t;

endpackage

`default_nettype wire

// File: rtl/ft_byte_fifo.sv
// ft_byte_fifo: synchronous pDepth x 8 FIFO with combinational head read.
// Rev 1.0
`default_nettype none

module ft_byte_fifo
  import ft2232h_pkg::*;
#(
  parameter int pDepth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [BYTE_W-1:0]         push_data,
  input  logic                      pop,
  output logic [BYTE_W-1:0]         head,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(pDepth):0]   count
);

  localparam int AW = $clog2(pDepth);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem [pDepth];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer only lands when the same edge frees a slot.
  assign do_pop  = pop && !empty && !rst;
  assign do_push = push && !rst && (!full || do_pop);

  assign full  = (count == CW'(pDepth));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/ft2232h_async_responder.sv
// ft2232h_async_responder: FT2232H-side async 245-FIFO responder bridging to host byte streams.
// Rev 1.0
`default_nettype none

module ft2232h_async_responder
  import ft2232h_pkg::*;
#(
  parameter int pDepth     = 16,
  parameter int pPrecharge = PRECHARGE_DEFAULT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [BYTE_W-1:0] iHostRxData,
  input  logic              iHostRxValid,
  output logic              oHostRxReady,
  output logic [BYTE_W-1:0] oHostTxData,
  output logic              oHostTxValid,
  input  logic              iHostTxReady,
  output logic [BYTE_W-1:0] oFifoData,
  output logic              oFifoDataOe,
  input  logic [BYTE_W-1:0] iFifoData,
  output logic              oRxF_n,
  output logic              oTxE_n,
  input  logic              iRx_n,
  input  logic              iTx_n,
  input  logic              iSiwu,
  output logic              oWake,
  output logic              oErrUnderrun,
  output logic              oErrOverrun
);

  localparam int CW = $clog2(pDepth) + 1;
  localparam int PW = (pPrecharge > 0) ? $clog2(pPrecharge + 1) : 1;

  logic              rx_prev, tx_prev, siwu_prev;
  logic              rx_rise, rx_fall, tx_rise, tx_fall;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic              rx_push, tx_pop;
  logic [CW-1:0]     rx_count, tx_count;
  logic [BYTE_W-1:0] rx_head;

  flag_state_t       rx_state, tx_state;
  logic [PW-1:0]     rx_cnt, tx_cnt;

  assign rx_rise = iRx_n && !rx_prev;
  assign rx_fall = !iRx_n && rx_prev;
  assign tx_rise = iTx_n && !tx_prev;
  assign tx_fall = !iTx_n && tx_prev;

  assign oHostRxReady = !rx_full && !iRst;
  assign oHostTxValid = !tx_empty && !iRst;
  assign rx_push      = iHostRxValid && oHostRxReady;
  assign tx_pop       = iHostTxReady && oHostTxValid;

  assign oFifoDataOe = !iRx_n && !iRst;
  assign oFifoData   = rx_empty ? '0 : rx_head;

  ft_byte_fifo #(.pDepth(pDepth)) u_rx_fifo (
    .clk       (iClk),
    .rst       (iRst),
    .push      (rx_push),
    .push_data (iHostRxData),
    .pop       (rx_rise),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  ft_byte_fifo #(.pDepth(pDepth)) u_tx_fifo (
    .clk       (iClk),
    .rst       (iRst),
    .push      (tx_fall),
    .push_data (iFifoData),
    .pop       (tx_pop),
    .head      (oHostTxData),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_prev      <= 1'b1;
      tx_prev      <= 1'b1;
      siwu_prev    <= 1'b1;
      oWake        <= 1'b0;
      oErrUnderrun <= 1'b0;
      oErrOverrun  <= 1'b0;
    end else begin
      rx_prev   <= iRx_n;
      tx_prev   <= iTx_n;
      siwu_prev <= iSiwu;
      oWake     <= !iSiwu && siwu_prev;
      if (rx_fall && rx_empty)           oErrUnderrun <= 1'b1;
      if (tx_fall && tx_full && !tx_pop) oErrOverrun  <= 1'b1;
    end
  end

  // Flag is registered from the pre-edge state, so it rises one edge after BUSY is entered.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_state <= FLAG_READY;
      rx_cnt   <= '0;
      oRxF_n   <= 1'b1;
    end else begin
      oRxF_n <= !(rx_state == FLAG_READY && rx_count != '0);
      case (rx_state)
        FLAG_READY: if (!iRx_n) rx_state <= FLAG_BUSY;
        FLAG_BUSY: begin
          if (rx_rise) begin
            rx_state <= (pPrecharge == 0) ? FLAG_READY : FLAG_PRECHARGE;
            rx_cnt   <= PW'(pPrecharge);
          end
        end
        FLAG_PRECHARGE: begin
          if (rx_cnt <= PW'(1)) begin
            rx_state <= FLAG_READY;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= FLAG_READY;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tx_state <= FLAG_READY;
      tx_cnt   <= '0;
      oTxE_n   <= 1'b1;
    end else begin
      oTxE_n <= !(tx_state == FLAG_READY && tx_count != CW'(pDepth));
      case (tx_state)
        FLAG_READY: if (!iTx_n) tx_state <= FLAG_BUSY;
        FLAG_BUSY: begin
          if (tx_rise) begin
            tx_state <= (pPrecharge == 0) ? FLAG_READY : FLAG_PRECHARGE;
            tx_cnt   <= PW'(pPrecharge);
          end
        end
        FLAG_PRECHARGE: begin
          if (tx_cnt <= PW'(1)) begin
            tx_state <= FLAG_READY;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= FLAG_READY;
      endcase
    end
  end

endmodule

`default_nettype wire
